cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
- Shares a single multi-cycle, pipelined main memory between the I-side and D-side cache miss handlers of the 5-stage pipeline.
- Grants the memory to one requester at a time with round-robin arbitration on contention.
- Sequences 8-word block fills (one read issued per cycle, data returns MEM_LAT cycles later) and single-word D-side write-through.
- Sits between the cache controllers and the memory model; the pipeline stalls on its requesters' busy/done handshakes.

Parameters:
ADDR_W, 16, address width (byte address)
DATA_W, 16, word width
BLOCK_WORDS, 8, words per cache block (block = 16 bytes)
MEM_LAT, 4, cycles from read issue to mem_rvalid

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
i_req  in  1  I-side fill request; held high until i_done
i_addr  in  16  I-side miss address; bits [3:0] ignored
i_fill_valid  out  1  I-side fill word valid
i_fill_word  out  3  index of word being returned
i_fill_data  out  16  fill data
i_done  out  1  one-cycle pulse with the last I-side fill word
d_req  in  1  D-side request; held high until d_done
d_wr  in  1  with d_req: 1 = single-word write, 0 = block fill
d_addr  in  16  D-side address (fill: bits [3:0] ignored; write: bit 0 ignored)
d_wdata  in  16  write data
d_fill_valid  out  1  D-side fill word valid
d_fill_word  out  3  index of word being returned
d_fill_data  out  16  fill data
d_done  out  1  one-cycle pulse: last fill word, or write issued
mem_en  out  1  memory access this cycle
mem_wr  out  1  1 = write
mem_addr  out  16  memory byte address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_rvalid  in  1  mem_rdata valid
busy  out  1  state != IDLE

Behaviour:
- Reset: clk and rst_n, as stated above. Asynchronous, active-low. State = IDLE, counters = 0, last_grant = I. All outputs are 0 while in reset and in IDLE.
- States: IDLE, FILL, WRITE.
- IDLE:
  - At a clock edge, sample i_req and d_req.
  - Only one request high: grant it.
  - Both high: grant the side opposite last_grant. After reset, D wins first.
  - Granting D with d_wr = 1 goes to WRITE; any other grant goes to FILL.
  - Latch the owner and block base = addr[15:4]. Update last_grant.
- FILL:
  - The issue counter k runs 0..7. In FILL cycle k: mem_en = 1, mem_wr = 0, mem_addr = {base, k[2:0], 1'b0}.
  - After 8 issues, mem_en = 0.
  - Receive counter r: each mem_rvalid in FILL drives the owner's fill_valid = 1, fill_data = mem_rdata (combinational pass-through), fill_word = r, then r increments.
  - The owner's done pulse is asserted with the word where r == 7. Next state is IDLE.
  - Latency: first issue is 1 cycle after the grant edge. For grant at edge 0, issues occur in cycles 1..8, rvalid in cycles 5..12, done in cycle 12, IDLE in cycle 13. The earliest next grant is at the edge ending cycle 13.
  - Non-owner outputs stay 0.
- WRITE:
  - For exactly one cycle: mem_en = 1, mem_wr = 1, mem_addr = {d_addr[15:1], 1'b0}, mem_wdata = d_wdata, d_done = 1.
  - Next state is IDLE.
- Boundary cases:
  - Requester dropping req mid-operation: ignored; the fill runs to completion.
  - mem_rvalid in IDLE or WRITE: ignored.
  - Extra mem_rvalid after r == 7: cannot occur (the FSM leaves FILL).
  - New requests during busy: not sampled until IDLE.
  - d_wr changing mid-operation: ignored.
  - Reset mid-fill: immediate return to IDLE with all outputs 0. The memory shares rst_n, so no stale returns arrive.
  - Counter widths: issue 4 bits (saturates at 8), receive 3 bits plus done detect. No arithmetic wrap outside the block.

Decomposition:
- Shared package holds:
  - state encoding (IDLE / FILL / WRITE)
  - owner encoding (OWN_I = 0, OWN_D = 1)
  - BLOCK_WORDS, MEM_LAT, WORD_IDX_W = 3
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter holding the last_grant flop. It takes req[1:0] and an update enable; it outputs one-hot grant.

Test Plan:
- I-side fill:
  - Stimulus: i_req = 1, i_addr = 0x1236 at edge 0; memory model returns rdata = addr.
  - Required: mem_en in cycles 1..8 with addr 0x1230, 0x1232, …, 0x123E; i_fill_valid in cycles 5..12 with word 0..7 and data 0x1230..0x123E; i_done in cycle 12; busy = 0 in cycle 13.
- Contention after reset:
  - Stimulus: i_req = d_req = 1 (d_wr = 0, d_addr = 0x4000).
  - Required: D block 0x4000..0x400E served first, d_done in cycle 12; the I fill's first mem_en is in cycle 14; no I-side valid before then.
- Round robin:
  - Stimulus: D re-requests immediately after d_done while I is still pending.
  - Required: I is granted next; D only after i_done.
- Write-through:
  - Stimulus: d_req = 1, d_wr = 1, d_addr = 0x0041, d_wdata = 0xBEEF.
  - Required: one cycle with mem_en = mem_wr = 1, mem_addr = 0x0040, mem_wdata = 0xBEEF, d_done = 1; no fill_valid; busy = 0 the next cycle.
- Reset mid-fill:
  - Stimulus: rst_n low in cycle 6 of an I fill.
  - Required: all outputs 0 asynchronously; after release, a new D fill starts at word 0 and completes normally.
- Robustness:
  - Stimulus: mem_rvalid pulsed in IDLE; separately, i_req dropped in cycle 3 of a fill.
  - Required: no fill_valid from the IDLE pulse; the interrupted fill still returns all 8 words and i_done.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: widths, block geometry,
// FSM state encoding and requester (owner) encoding.
package cache_fill_arbiter_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned MEM_LAT     = 4;
    localparam int unsigned WORD_IDX_W  = 3;
    // One extra bit so the issue counter can rest at BLOCK_WORDS once all reads are out.
    localparam int unsigned ISSUE_W     = WORD_IDX_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/cache_fill_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit OWN_I = I-side, bit OWN_D = D-side
//   update     : when high and a grant is given, remember the winner at the edge
//   grant[1:0] : one-hot grant (combinational)
// On contention the side opposite the last winner is granted. The last winner
// resets to I, so the D-side wins the first contended grant after reset.
module rr_arb2
    import cache_fill_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == OWN_I) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_I;
        end else if (update && (|req)) begin
            last_q <= grant[OWN_D];
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined main memory between the I-side and D-side miss handlers.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_req, i_addr              : I-side block fill request (held until i_done)
//   i_fill_valid/word/data     : I-side returned fill words, i_done with the last
//   d_req, d_wr, d_addr, d_wdata : D-side block fill (d_wr=0) or single write (d_wr=1)
//   d_fill_valid/word/data     : D-side returned fill words, d_done with last word/write
//   mem_en/wr/addr/wdata       : memory command, one per cycle
//   mem_rdata, mem_rvalid      : memory read return, MEM_LAT cycles after issue
//   busy                       : arbiter is serving a request
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_fill_valid,
    output logic [WORD_IDX_W-1:0] i_fill_word,
    output logic [DATA_W-1:0]     i_fill_data,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_fill_valid,
    output logic [WORD_IDX_W-1:0] d_fill_word,
    output logic [DATA_W-1:0]     d_fill_data,
    output logic                  d_done,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_W-1:1]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [ISSUE_W-1:0]    issue_q, issue_d;
    logic [WORD_IDX_W-1:0] recv_q, recv_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       arb_update;
    logic       issuing;
    logic       fill_hit;
    logic       last_word;

    // Byte-select bits never reach the memory (word-aligned accesses only).
    logic unused_addr_bits;
    assign unused_addr_bits = i_addr[0] ^ d_addr[0];

    assign req        = {d_req, i_req};
    assign arb_update = (state_q == StIdle);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (arb_update),
        .grant  (grant)
    );

    assign issuing   = (state_q == StFill) && (issue_q < ISSUE_W'(BLOCK_WORDS));
    assign fill_hit  = (state_q == StFill) && mem_rvalid;
    assign last_word = (recv_q == WORD_IDX_W'(BLOCK_WORDS - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        issue_d = issue_q;
        recv_d  = recv_q;

        unique case (state_q)
            StIdle: begin
                if (grant[OWN_D]) begin
                    owner_d = OWN_D;
                    addr_d  = d_addr[ADDR_W-1:1];
                    wdata_d = d_wdata;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = d_wr ? StWrite : StFill;
                end else if (grant[OWN_I]) begin
                    owner_d = OWN_I;
                    addr_d  = i_addr[ADDR_W-1:1];
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (issuing) begin
                    issue_d = issue_q + 1'b1;
                end
                if (mem_rvalid) begin
                    recv_d = recv_q + 1'b1;
                    if (last_word) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: everything is zero unless the FSM is actively serving an owner.
    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_fill_valid = 1'b0;
        i_fill_word  = '0;
        i_fill_data  = '0;
        i_done       = 1'b0;
        d_fill_valid = 1'b0;
        d_fill_word  = '0;
        d_fill_data  = '0;
        d_done       = 1'b0;
        busy         = (state_q != StIdle);

        if (state_q == StWrite) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {addr_q, 1'b0};
            mem_wdata = wdata_q;
            d_done    = 1'b1;
        end

        if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:4], issue_q[WORD_IDX_W-1:0], 1'b0};
        end

        // Read data passes straight through to the owning side.
        if (fill_hit) begin
            if (owner_q == OWN_I) begin
                i_fill_valid = 1'b1;
                i_fill_word  = recv_q;
                i_fill_data  = mem_rdata;
                i_done       = last_word;
            end else begin
                d_fill_valid = 1'b1;
                d_fill_word  = recv_q;
                d_fill_data  = mem_rdata;
                d_done       = last_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed timing checks plus randomized rounds,
// with a queue-based scoreboard checked by an independent monitor.
module tb_cache_fill_arbiter;
    import cache_fill_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_fill_valid, i_done, d_fill_valid, d_done;
    logic [2:0]  i_fill_word, d_fill_word;
    logic [15:0] i_fill_data, d_fill_data;
    logic        mem_en, mem_wr, busy;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_rvalid = 1'b0;
    logic        inject_rv = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_fill_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_fill_valid (i_fill_valid),
        .i_fill_word  (i_fill_word),
        .i_fill_data  (i_fill_data),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_fill_valid (d_fill_valid),
        .d_fill_word  (d_fill_word),
        .d_fill_data  (d_fill_data),
        .d_done       (d_done),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .busy         (busy)
    );

    logic any_out;
    assign any_out = |{busy, mem_en, mem_wr, mem_addr, mem_wdata, i_fill_valid, i_fill_word,
                       i_fill_data, i_done, d_fill_valid, d_fill_word, d_fill_data, d_done};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model: rdata = address, fixed latency ----------------
    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;
    rd_t rd_q[$];

    always @(negedge clk) begin
        rd_t nr;
        if (!rst_n) begin
            rd_q.delete();
        end else if (mem_en && !mem_wr) begin
            nr.addr = mem_addr;
            nr.due  = cyc + int'(MEM_LAT);
            rd_q.push_back(nr);
        end
    end

    always @(posedge clk) begin
        rd_t r;
        #1;
        mem_rvalid = inject_rv;
        mem_rdata  = 16'h0;
        if (rst_n && rd_q.size() > 0 && rd_q[0].due == cyc) begin
            r          = rd_q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = r.addr;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_op_t;

    mem_op_t     mem_exp[$];
    logic [18:0] i_exp[$];
    logic [18:0] d_exp[$];
    logic        order_exp[$];
    logic        model_last = 1'b0;

    // One granted transaction: its memory commands, its fill words and its done.
    task automatic expect_txn(input logic side, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata);
        mem_op_t     op;
        logic [15:0] a;
        order_exp.push_back(side);
        if (side && wr) begin
            op.wr    = 1'b1;
            op.addr  = {addr[15:1], 1'b0};
            op.wdata = wdata;
            mem_exp.push_back(op);
        end else begin
            for (int w = 0; w < int'(BLOCK_WORDS); w++) begin
                a        = {addr[15:4], 4'h0} + 16'(2 * w);
                op.wr    = 1'b0;
                op.addr  = a;
                op.wdata = 16'h0;
                mem_exp.push_back(op);
                if (side) d_exp.push_back({3'(w), a});
                else      i_exp.push_back({3'(w), a});
            end
        end
        model_last = side;
    endtask

    task automatic clear_model();
        mem_exp.delete();
        i_exp.delete();
        d_exp.delete();
        order_exp.delete();
        model_last = 1'b0;
    endtask

    always @(negedge clk) begin
        mem_op_t     eo;
        logic [18:0] ef;
        logic        es;
        if (rst_n) begin
            if (mem_en) begin
                if (mem_exp.size() == 0) begin
                    check("mem_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    eo = mem_exp.pop_front();
                    check("mem_wr", 32'(mem_wr), 32'(eo.wr));
                    check("mem_addr", 32'(mem_addr), 32'(eo.addr));
                    if (eo.wr) check("mem_wdata", 32'(mem_wdata), 32'(eo.wdata));
                end
            end
            if (i_fill_valid) begin
                if (i_exp.size() == 0) begin
                    check("i_fill_unexpected", 32'(i_fill_valid), 32'd0);
                end else begin
                    ef = i_exp.pop_front();
                    check("i_fill_word", 32'(i_fill_word), 32'(ef[18:16]));
                    check("i_fill_data", 32'(i_fill_data), 32'(ef[15:0]));
                    check("i_done_on_last", 32'(i_done), 32'(ef[18:16] == 3'd7));
                end
            end
            if (d_fill_valid) begin
                if (d_exp.size() == 0) begin
                    check("d_fill_unexpected", 32'(d_fill_valid), 32'd0);
                end else begin
                    ef = d_exp.pop_front();
                    check("d_fill_word", 32'(d_fill_word), 32'(ef[18:16]));
                    check("d_fill_data", 32'(d_fill_data), 32'(ef[15:0]));
                    check("d_done_on_last", 32'(d_done), 32'(ef[18:16] == 3'd7));
                end
            end
            if (i_done && !i_fill_valid) check("i_done_stray", 32'(i_done), 32'd0);
            if (d_done && !d_fill_valid && !(mem_en && mem_wr))
                check("d_done_stray", 32'(d_done), 32'd0);
            if (i_done || d_done) begin
                if (order_exp.size() == 0) begin
                    check("done_unexpected", 32'(i_done | d_done), 32'd0);
                end else begin
                    es = order_exp.pop_front();
                    check("grant_order", 32'(d_done), 32'(es));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done(input logic side, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (side ? d_done : i_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(side ? "d_done_timeout" : "i_done_timeout",
                          32'(side ? d_done : i_done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          b, at, choice, gap;
        logic        first, s, dwr;
        logic [15:0] ia, da, dw;

        i_req = 0; d_req = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 32'(any_out), 32'd0);
        rst_n = 1;
        @(negedge clk);
        check("idle_outputs_zero", 32'(any_out), 32'd0);

        // Contention after reset, then D re-requests while I is pending.
        b = cyc;
        i_req = 1; i_addr = 16'h1236;
        d_req = 1; d_wr = 0; d_addr = 16'h4000;
        expect_txn(1'b1, 1'b0, 16'h4000, 16'h0);
        expect_txn(1'b0, 1'b0, 16'h1236, 16'h0);
        expect_txn(1'b1, 1'b0, 16'h5000, 16'h0);
        wait_done(1'b1, 40, at);
        check("cont_d_done_cycle", 32'(at), 32'(b + 12));
        check("cont_no_i_before_d", 32'(i_exp.size()), 32'd8);
        d_addr = 16'h5000;
        wait_until(b + 13);
        check("cont_idle_busy", 32'(busy), 32'd0);
        check("cont_idle_mem_en", 32'(mem_en), 32'd0);
        wait_until(b + 14);
        check("cont_i_first_issue", 32'(mem_en), 32'd1);
        wait_done(1'b0, 40, at);
        check("rr_i_done_cycle", 32'(at), 32'(b + 25));
        i_req = 0;
        wait_done(1'b1, 40, at);
        check("rr_d_done_cycle", 32'(at), 32'(b + 38));
        d_req = 0;
        @(negedge clk);

        // Write-through.
        b = cyc;
        d_req = 1; d_wr = 1; d_addr = 16'h0041; d_wdata = 16'hBEEF;
        expect_txn(1'b1, 1'b1, 16'h0041, 16'hBEEF);
        wait_done(1'b1, 5, at);
        check("wr_done_cycle", 32'(at), 32'(b + 1));
        check("wr_mem_wr", 32'(mem_wr), 32'd1);
        check("wr_no_fill", 32'(i_fill_valid | d_fill_valid), 32'd0);
        d_req = 0; d_wr = 0;
        @(negedge clk);
        check("wr_busy_after", 32'(busy), 32'd0);

        // I fill with exact timing; i_req dropped in cycle 3; rvalid pulsed in IDLE.
        b = cyc;
        i_req = 1; i_addr = 16'h1236;
        expect_txn(1'b0, 1'b0, 16'h1236, 16'h0);
        wait_until(b + 1);
        check("fill_first_issue", 32'(mem_en), 32'd1);
        wait_until(b + 3);
        i_req = 0;
        wait_until(b + 4);
        check("fill_no_valid_c4", 32'(i_fill_valid), 32'd0);
        wait_until(b + 5);
        check("fill_first_valid_c5", 32'(i_fill_valid), 32'd1);
        wait_until(b + 8);
        check("fill_last_issue", 32'(mem_en), 32'd1);
        wait_until(b + 9);
        check("fill_issue_stop", 32'(mem_en), 32'd0);
        wait_done(1'b0, 10, at);
        check("fill_i_done_cycle", 32'(at), 32'(b + 12));
        @(negedge clk);
        check("fill_busy_after", 32'(busy), 32'd0);
        inject_rv = 1;
        @(negedge clk);
        inject_rv = 0;
        check("idle_rvalid_ignored", 32'(i_fill_valid | d_fill_valid | busy), 32'd0);

        // Reset in the middle of an I fill.
        b = cyc;
        i_req = 1; i_addr = 16'h7770;
        expect_txn(1'b0, 1'b0, 16'h7770, 16'h0);
        wait_until(b + 6);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 0;
        #1;
        check("reset_async_outputs", 32'(any_out), 32'd0);
        clear_model();
        i_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        b = cyc;
        d_req = 1; d_wr = 0; d_addr = 16'h2346;
        i_req = 1; i_addr = 16'h3330;
        expect_txn(1'b1, 1'b0, 16'h2346, 16'h0);
        expect_txn(1'b0, 1'b0, 16'h3330, 16'h0);
        wait_done(1'b1, 20, at);
        check("post_reset_d_done", 32'(at), 32'(b + 12));
        d_req = 0;
        wait_done(1'b0, 20, at);
        check("post_reset_i_done", 32'(at), 32'(b + 25));
        i_req = 0;

        // Randomized rounds.
        for (int round = 0; round < 40; round++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            choice = $urandom_range(0, 2);
            ia  = 16'($urandom);
            da  = 16'($urandom);
            dw  = 16'($urandom);
            dwr = 1'($urandom_range(0, 1));
            if (choice == 2) begin
                first = ~model_last;
                for (int j = 0; j < 2; j++) begin
                    s = (j == 0) ? first : ~first;
                    if (s) expect_txn(1'b1, dwr, da, dw);
                    else   expect_txn(1'b0, 1'b0, ia, 16'h0);
                end
            end else if (choice == 1) begin
                expect_txn(1'b1, dwr, da, dw);
            end else begin
                expect_txn(1'b0, 1'b0, ia, 16'h0);
            end
            i_addr = ia; d_addr = da; d_wdata = dw; d_wr = dwr;
            i_req = (choice != 1);
            d_req = (choice != 0);
            for (int k = 0; k < 80 && (i_req || d_req); k++) begin
                @(negedge clk);
                if (i_done) i_req = 0;
                if (d_done) begin
                    d_req = 0;
                    d_wr  = 0;
                end
            end
            if (i_req || d_req) begin
                check("rand_round_timeout", 32'({i_req, d_req}), 32'd0);
                i_req = 0;
                d_req = 0;
            end
        end

        repeat (3) @(negedge clk);
        check("end_mem_exp_empty", 32'(mem_exp.size()), 32'd0);
        check("end_i_exp_empty", 32'(i_exp.size()), 32'd0);
        check("end_d_exp_empty", 32'(d_exp.size()), 32'd0);
        check("end_order_empty", 32'(order_exp.size()), 32'd0);
        check("end_idle", 32'(any_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
